// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, opcodes,
// ALU operations, immediate formats, datapath mux selects and the branch condition.
package rv32i_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational funct3/instr[30] to ALU operation map; instr[30] means SUB
// only for register-register ops, but selects SRA for both R and I shifts.
import rv32i_ctrl_pkg::*;

module alu_decoder (
  input  logic [2:0] funct3,
  input  logic       bit30,
  input  logic       is_r,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (is_r && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// RV32I multicycle control FSM: Moore outputs per state, memory access completes after MEM_LAT
// cycles, or on mem_ready when MEM_HANDSHAKE_EN is defined (stalls indefinitely while low).
import rv32i_ctrl_pkg::*;

module multicycle_control #(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  EQ,
  input  logic                  LT,
  input  logic                  LTU,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  AdrSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [ALU_CTRL_W-1:0] ALUctrl,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic                  illegal
);

  state_t     state, state_nx;
  logic       jalr_ph;
  logic       illegal_q;
  logic       mem_st;
  logic       done;
  logic [3:0] dec_op;
  logic [3:0] alu_sel;
  logic [2:0] imm_sel;
  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign mem_st      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], mem_ready};

`ifdef MEM_HANDSHAKE_EN
  assign done = mem_st && mem_ready;
`else
  logic [3:0] cnt;

  assign done = mem_st && (cnt == 4'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (mem_st && !done) cnt <= cnt + 4'd1;
    else                    cnt <= '0;
  end
`endif

  alu_decoder u_alu_dec (
    .funct3 (instr[14:12]),
    .bit30  (instr[30]),
    .is_r   (state == S_EXECR),
    .alu_op (dec_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      jalr_ph   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state   <= state_nx;
      jalr_ph <= (state == S_JALR) && !jalr_ph;
      if (state_nx == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Everything is held at zero while rst is high, whatever state is registered.
  always_comb begin
    state_nx  = state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    alu_sel   = ALU_ADD;
    imm_sel   = IMM_I;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (done) begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            state_nx = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          imm_sel = (opcode == OP_JAL) ? IMM_J : IMM_B;
          case (opcode)
            OP_LOAD, OP_STORE: state_nx = S_MEMADR;
            OP_R:              state_nx = S_EXECR;
            OP_I:              state_nx = S_EXECI;
            OP_BRANCH:         state_nx = S_BRANCH;
            OP_JAL:            state_nx = S_JAL;
            OP_JALR:           state_nx = S_JALR;
            OP_LUI:            state_nx = S_LUI;
            default:           state_nx = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_IMM;
          imm_sel  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
          state_nx = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
          if (done) state_nx = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_RDATA;
          RegWrite  = 1'b1;
          state_nx  = S_FETCH;
        end
        S_MEMWR: begin
          AdrSrc = 1'b1;
`ifdef MEM_HANDSHAKE_EN
          MemWrite = 1'b1;
`else
          MemWrite = done;
`endif
          if (done) state_nx = S_FETCH;
        end
        S_EXECR: begin
          ALUSrcA  = SRCA_RS1;
          alu_sel  = dec_op;
          state_nx = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA  = SRCA_RS1;
          ALUSrcB  = SRCB_IMM;
          alu_sel  = dec_op;
          state_nx = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          state_nx = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA  = SRCA_RS1;
          alu_sel  = ALU_SUB;
          PCWrite  = branch_taken(instr[14:12], EQ, LT, LTU);
          state_nx = S_FETCH;
        end
        S_JAL: begin
          imm_sel  = IMM_J;
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_FOUR;
          PCWrite  = 1'b1;
          state_nx = S_ALUWB;
        end
        S_JALR: begin
          // Phase 0 forms rs1+imm; phase 1 loads PC from it and forms the link value.
          if (!jalr_ph) begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
          end else begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            PCWrite  = 1'b1;
            state_nx = S_ALUWB;
          end
        end
        S_LUI: begin
          imm_sel  = IMM_U;
          ALUSrcB  = SRCB_IMM;
          alu_sel  = ALU_PASSB;
          state_nx = S_ALUWB;
        end
        S_TRAP:  state_nx = S_TRAP;
        default: state_nx = S_FETCH;
      endcase
    end
  end

  assign ALUctrl = ALU_CTRL_W'(alu_sel);
  assign ImmSrc  = IMM_SRC_W'(imm_sel);
  assign illegal = illegal_q && !rst;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the RV32I core, successor to the single-cycle decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback over a shared memory port and shared ALU. It drives all datapath enables and muxes every cycle, resolves all six branch conditions, and supports a configurable or handshaked memory latency. It sits between the instruction register/ALU flags and the multicycle datapath.

## Interface
- ALU_CTRL_W, 4, width of ALUctrl
- IMM_SRC_W, 3, width of ImmSrc
- MEM_LAT, 1, fixed memory access cycles (1..15) used when handshake is compiled out
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- instr  in  32  instruction register contents (valid from DECODE on)
- EQ, LT, LTU  in  1 each  ALU compare flags for rs1 vs rs2
- mem_ready  in  1  memory access done (used only with MEM_HANDSHAKE_EN)
- PCWrite, IRWrite, RegWrite, MemWrite, MemRead  out  1 each  datapath enables
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- ALUctrl  out  ALU_CTRL_W  operation select
- ImmSrc  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  sticky unsupported-opcode flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUctrl=ADD, ResultSrc=10. On access completion: IRWrite=1 and PCWrite=1 for that one cycle only, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, ALUctrl=ADD (branch target into ALUOut). Dispatch by opcode:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - otherwise → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I for loads or S for stores, ALUctrl=ADD. Then MEMRD for loads, MEMWR for stores.
- MEMRD: AdrSrc=1, MemRead=1 until completion, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1 until completion, then FETCH.
- EXECR: ALUctrl decoded from funct3 and instr[30]: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- EXECI: same decode, except instr[30] selects SRA only when funct3=101. Both EXEC states go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=SUB, ResultSrc=00. PCWrite = taken, where taken is:
  - beq: EQ; bne: !EQ
  - blt: LT; bge: !LT
  - bltu: LTU; bgeu: !LTU
  - funct3 010/011: never taken
  - Then FETCH.
- JAL: ImmSrc=J, ALUSrcA=01, ALUSrcB=10, ALUctrl=ADD, ResultSrc=00, PCWrite=1 (DECODE must have used ImmSrc=J for this opcode). Then ALUWB, which writes PC+4.
- JALR: first cycle computes rs1+imm (I) into ALUOut. Second cycle does PCWrite from ALUOut with LSB cleared by the datapath, then ALUWB.
- LUI: ImmSrc=U, ALUSrcB=01, ALUctrl=PASSB, then ALUWB.
- TRAP: all enables 0, illegal=1. Leave only on rst.
- Outputs are Moore functions of state, plus instr/flags where noted. Every enable not listed for a state is 0.

## Timing
- Reset: state=FETCH, latency counter=0, illegal=0. While rst is high, all outputs are 0; ALUctrl, ImmSrc and the mux selects are 0.
- rst asserted in any state → FETCH on the next edge. An in-flight write is abandoned with no further enable.
- Access completion, macro off: counter reaches MEM_LAT-1. Enables such as MemRead/MemWrite stay asserted across all access cycles, but MemWrite is a single-cycle pulse on the final cycle.
- Cycle counts with MEM_LAT=1:
  - R/I/LUI: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- Each memory access adds MEM_LAT-1 cycles. The counter wraps to 0 on completion.

## Configuration
- MEM_HANDSHAKE_EN defined: completion is mem_ready sampled high during FETCH/MEMRD/MEMWR. The FSM stalls indefinitely while it is low. MEM_LAT is ignored. MemWrite is held until mem_ready.
- MEM_HANDSHAKE_EN undefined: mem_ready is ignored and the fixed MEM_LAT counter is used.

## Structure
- Package rv32i_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALU op enum: ADD=0, SUB=1, XOR=2, AND=3, OR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10
  - ImmSrc and mux-select constants
- Sub-module alu_decoder: combinational map of funct3, instr[30] and R/I → ALUctrl.

## Test plan
- add x3,x1,x2 (0x002081B3), MEM_LAT=1 → FETCH, DECODE, EXECR, ALUWB; ALUctrl=0; RegWrite=1 only in cycle 4.
- lw (0x0000A183) with MEM_LAT=3 → 9 cycles; MemRead high 3 cycles in FETCH and 3 in MEMRD; ResultSrc=01 in MEMWB.
- bne (0x00209463): EQ=1 → no PCWrite in BRANCH. EQ=0 → PCWrite=1. Cycle count 3 in both cases.
- bgeu (funct3 111) with LTU=1 → not taken; with LTU=0 → taken.
- opcode 0x7F → TRAP, illegal=1 held for 20 cycles; rst → FETCH, illegal=0.
- rst during MEMWR → next cycle FETCH, MemWrite=0. With the macro defined, mem_ready low for 5 cycles → FSM held in FETCH with IRWrite=0.
